rggen_register_access_arbiter: RTL and testbench



---
 rtl/rggen_register_access_arbiter_pkg.sv | 24 ++
 rtl/rggen_register_access_arbiter_rr_selector.sv | 17 +
 rtl/rggen_register_access_arbiter.sv | 89 ++++++++
 tb/tb_rggen_register_access_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_register_access_arbiter_pkg.sv
// rggen_register_access_pkg: shared status/state encodings and round-robin pick for the register access arbiter
package rggen_register_access_pkg;
    typedef enum logic [1:0] {
        OKAY         = 2'd0,
        EXOKAY       = 2'd1,
        SLAVE_ERROR  = 2'd2,
        DECODE_ERROR = 2'd3
    } status_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Scanning offsets downwards leaves the requester closest to the pointer as the winner.
    function automatic int rr_next_index(input logic [31:0] request, input int pointer, input int hosts);
        int j;
        rr_next_index = pointer;
        for (int i = hosts - 1; i >= 0; i--) begin
            j = (pointer + i) % hosts;
            if (request[j]) rr_next_index = j;
        end
    endfunction
endpackage

// File: rtl/rggen_register_access_arbiter_rr_selector.sv
// rggen_rr_selector: picks the first requester at or after the round-robin pointer
module rggen_rr_selector
    import rggen_register_access_pkg::*;
#(
    parameter int HOSTS = 2,
    parameter int IW    = (HOSTS > 1) ? $clog2(HOSTS) : 1
)(
    input  logic [HOSTS-1:0] request,
    input  logic [IW-1:0]    pointer,
    output logic [IW-1:0]    grant,
    output logic             any_request
);
    always_comb begin
        grant       = IW'(rr_next_index(32'(request), int'(pointer), HOSTS));
        any_request = |request;
    end
endmodule

// File: rtl/rggen_register_access_arbiter.sv
// rggen_register_access_arbiter: round-robin sharing of one register-block bus port among several hosts
module rggen_register_access_arbiter
    import rggen_register_access_pkg::*;
#(
    parameter int HOSTS         = 2,
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32,
    parameter int TIMEOUT       = 0
)(
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [HOSTS-1:0]                 i_host_valid,
    input  logic [HOSTS-1:0]                 i_host_write,
    input  logic [HOSTS*ADDRESS_WIDTH-1:0]   i_host_address,
    input  logic [HOSTS*BUS_WIDTH-1:0]       i_host_write_data,
    input  logic [HOSTS*(BUS_WIDTH/8)-1:0]   i_host_strobe,
    output logic [HOSTS-1:0]                 o_host_ready,
    output logic [1:0]                       o_host_status,
    output logic [BUS_WIDTH-1:0]             o_host_read_data,
    output logic                             o_valid,
    output logic                             o_write,
    output logic [ADDRESS_WIDTH-1:0]         o_address,
    output logic [BUS_WIDTH-1:0]             o_write_data,
    output logic [BUS_WIDTH/8-1:0]           o_strobe,
    input  logic                             i_ready,
    input  logic [1:0]                       i_status,
    input  logic [BUS_WIDTH-1:0]             i_read_data
);
    localparam int IW = (HOSTS > 1) ? $clog2(HOSTS) : 1;
    localparam int SW = BUS_WIDTH / 8;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e        state;
    logic [IW-1:0] grant;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] sel;
    logic [CW-1:0] count;
    logic          any_request;
    logic          timeout;
    logic          done;

    rggen_rr_selector #(
        .HOSTS (HOSTS)
    ) u_selector (
        .request     (i_host_valid),
        .pointer     (rr_ptr),
        .grant       (sel),
        .any_request (any_request)
    );

    // A real i_ready always beats the watchdog in the same cycle.
    always_comb begin
        o_valid          = state == BUSY;
        timeout          = (TIMEOUT > 0) && o_valid && !i_ready && count == LIMIT;
        done             = o_valid && (i_ready || timeout);
        o_host_ready     = done ? HOSTS'(1) << grant : '0;
        o_host_status    = done ? (i_ready ? i_status : SLAVE_ERROR) : OKAY;
        o_host_read_data = (done && i_ready && !o_write) ? i_read_data : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            grant        <= '0;
            rr_ptr       <= '0;
            count        <= '0;
            o_write      <= 1'b0;
            o_address    <= '0;
            o_write_data <= '0;
            o_strobe     <= '0;
        end else if (state == IDLE) begin
            if (any_request) begin
                state        <= BUSY;
                grant        <= sel;
                count        <= '0;
                o_write      <= i_host_write[sel];
                o_address    <= i_host_address[sel*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                o_write_data <= i_host_write_data[sel*BUS_WIDTH +: BUS_WIDTH];
                o_strobe     <= i_host_strobe[sel*SW +: SW];
            end
        end else if (done) begin
            state  <= IDLE;
            rr_ptr <= (grant == IW'(HOSTS - 1)) ? '0 : grant + IW'(1);
        end else begin
            count <= count + CW'(1);
        end
    end
endmodule

// File: tb/tb_rggen_register_access_arbiter.sv
// tb_rggen_register_access_arbiter: scenario tasks plus randomized transactions against a transaction-level model
module tb_rggen_register_access_arbiter;
    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [1:0]  host_valid;
    logic [1:0]  host_write;
    logic [31:0] host_address;
    logic [63:0] host_write_data;
    logic [7:0]  host_strobe;
    logic [1:0]  host_ready;
    logic [1:0]  host_status;
    logic [31:0] host_read_data;
    logic        o_valid;
    logic        o_write;
    logic [15:0] o_address;
    logic [31:0] o_write_data;
    logic [3:0]  o_strobe;
    logic        i_ready;
    logic [1:0]  i_status;
    logic [31:0] i_read_data;

    logic        rv [2];
    logic        rw [2];
    logic [15:0] ra [2];
    logic [31:0] rd [2];
    logic [3:0]  rs [2];
    int          ptr_m;
    int          checks;
    int          errors;

    rggen_register_access_arbiter #(
        .HOSTS         (2),
        .ADDRESS_WIDTH (16),
        .BUS_WIDTH     (32),
        .TIMEOUT       (4)
    ) dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_host_valid      (host_valid),
        .i_host_write      (host_write),
        .i_host_address    (host_address),
        .i_host_write_data (host_write_data),
        .i_host_strobe     (host_strobe),
        .o_host_ready      (host_ready),
        .o_host_status     (host_status),
        .o_host_read_data  (host_read_data),
        .o_valid           (o_valid),
        .o_write           (o_write),
        .o_address         (o_address),
        .o_write_data      (o_write_data),
        .o_strobe          (o_strobe),
        .i_ready           (i_ready),
        .i_status          (i_status),
        .i_read_data       (i_read_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_hosts();
        for (int h = 0; h < 2; h++) begin
            host_valid[h]                 = rv[h];
            host_write[h]                 = rw[h];
            host_address[h*16 +: 16]      = ra[h];
            host_write_data[h*32 +: 32]   = rd[h];
            host_strobe[h*4 +: 4]         = rs[h];
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_ready = 1'b1;
        i_status = 2'd3;
        i_read_data = 32'h5555AAAA;
        #2;
        checks++;
        if (o_valid !== 1'b0 || host_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctrl got valid=%b ready=%b exp valid=0 ready=00", o_valid, host_ready);
        end
        checks++;
        if (host_status !== 2'd0 || host_read_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_resp got status=%0d data=%h exp status=0 data=0", host_status, host_read_data);
        end
        checks++;
        if ({o_write, o_address, o_write_data, o_strobe} !== 53'h0) begin
            errors++;
            $display("FAIL reset_payload got %h exp 0", {o_write, o_address, o_write_data, o_strobe});
        end
        step();
        step();
        i_rst_n = 1'b1;
        i_ready = 1'b0;
        i_status = 2'd0;
    endtask

    task automatic test_single_read();
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 16'h0010; rd[0] = $urandom; rs[0] = 4'hF;
        drive_hosts();
        #1;
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_t0_valid got %b exp 0", o_valid);
        end
        step();
        i_ready = 1'b1; i_read_data = 32'hDEADBEEF; i_status = 2'd0;
        #1;
        checks++;
        if ({o_valid, o_write, o_address} !== {1'b1, 1'b0, 16'h0010}) begin
            errors++;
            $display("FAIL read_req got v=%b w=%b a=%h exp v=1 w=0 a=0010", o_valid, o_write, o_address);
        end
        checks++;
        if (host_ready !== 2'b01 || host_read_data !== 32'hDEADBEEF || host_status !== 2'd0) begin
            errors++;
            $display("FAIL read_resp got rdy=%b d=%h s=%0d exp rdy=01 d=deadbeef s=0", host_ready, host_read_data, host_status);
        end
        step();
        rv[0] = 1'b0;
        drive_hosts();
        i_ready = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || host_ready !== 2'b00) begin
            errors++;
            $display("FAIL read_t2_idle got v=%b rdy=%b exp v=0 rdy=00", o_valid, host_ready);
        end
        ptr_m = 1;
    endtask

    task automatic test_write_hold();
        rv[1] = 1'b1; rw[1] = 1'b1; ra[1] = 16'h0004; rd[1] = 32'h12345678; rs[1] = 4'b0011;
        drive_hosts();
        i_ready = 1'b0;
        step();
        rw[1] = 1'b0; ra[1] = 16'hFFFF; rd[1] = 32'hA5A5A5A5; rs[1] = 4'b1100;
        drive_hosts();
        for (int b = 0; b < 3; b++) begin
            i_ready = (b == 2); i_status = 2'd1; i_read_data = 32'hCAFEF00D;
            #1;
            checks++;
            if ({o_valid, o_write, o_address, o_write_data, o_strobe} !== {1'b1, 1'b1, 16'h0004, 32'h12345678, 4'b0011}) begin
                errors++;
                $display("FAIL hold_payload cyc%0d got w=%b a=%h d=%h s=%b exp w=1 a=0004 d=12345678 s=0011",
                         b, o_write, o_address, o_write_data, o_strobe);
            end
            checks++;
            if (host_ready !== ((b == 2) ? 2'b10 : 2'b00)) begin
                errors++;
                $display("FAIL hold_ready cyc%0d got %b exp %b", b, host_ready, (b == 2) ? 2'b10 : 2'b00);
            end
            if (b == 2) begin
                checks++;
                if (host_status !== 2'd1 || host_read_data !== 32'h0) begin
                    errors++;
                    $display("FAIL write_resp got s=%0d d=%h exp s=1 d=0", host_status, host_read_data);
                end
            end
            step();
        end
        rv[1] = 1'b0;
        drive_hosts();
        i_ready = 1'b0;
        ptr_m = 0;
    endtask

    task automatic test_back_to_back();
        int g;
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 16'h00A0; rd[0] = $urandom; rs[0] = 4'hF;
        rv[1] = 1'b1; rw[1] = 1'b1; ra[1] = 16'h00B0; rd[1] = $urandom; rs[1] = 4'h5;
        drive_hosts();
        i_ready = 1'b1; i_status = 2'd0;
        g = ptr_m;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (host_ready !== ((k % 2 == 1) ? 2'(1 << g) : 2'b00)) begin
                errors++;
                $display("FAIL b2b_ready cyc%0d got %b exp %b", k, host_ready, (k % 2 == 1) ? 2'(1 << g) : 2'b00);
            end
            if (k % 2 == 1) begin
                checks++;
                if (o_address !== ra[g]) begin
                    errors++;
                    $display("FAIL b2b_grant cyc%0d got addr=%h exp %h", k, o_address, ra[g]);
                end
                g = 1 - g;
            end
            step();
        end
        rv[0] = 1'b0; rv[1] = 1'b0;
        drive_hosts();
        i_ready = 1'b0;
        ptr_m = g;
    endtask

    task automatic test_timeout();
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 16'h0020;
        drive_hosts();
        i_ready = 1'b0; i_read_data = 32'h87654321; i_status = 2'd0;
        step();
        for (int b = 0; b < 4; b++) begin
            #1;
            checks++;
            if (host_ready !== ((b == 3) ? 2'b01 : 2'b00)) begin
                errors++;
                $display("FAIL tmo_ready cyc%0d got %b exp %b", b, host_ready, (b == 3) ? 2'b01 : 2'b00);
            end
            if (b == 3) begin
                checks++;
                if (host_status !== 2'd2 || host_read_data !== 32'h0) begin
                    errors++;
                    $display("FAIL tmo_resp got s=%0d d=%h exp s=2 d=0", host_status, host_read_data);
                end
            end
            step();
        end
        rv[0] = 1'b0;
        drive_hosts();
        i_ready = 1'b1;
        #1;
        checks++;
        if (host_ready !== 2'b00 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL tmo_late_ready got rdy=%b v=%b exp rdy=00 v=0", host_ready, o_valid);
        end
        step();
        i_ready = 1'b0;
        ptr_m = 1;
    endtask

    task automatic test_ready_at_limit();
        logic [31:0] v;
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 16'h0030;
        drive_hosts();
        i_ready = 1'b0;
        step();
        for (int b = 0; b < 4; b++) begin
            v = $urandom;
            i_ready = (b == 3); i_status = 2'd0; i_read_data = v;
            #1;
            checks++;
            if (host_ready !== ((b == 3) ? 2'b01 : 2'b00)) begin
                errors++;
                $display("FAIL limit_ready cyc%0d got %b exp %b", b, host_ready, (b == 3) ? 2'b01 : 2'b00);
            end
            if (b == 3) begin
                checks++;
                if (host_status !== 2'd0 || host_read_data !== v) begin
                    errors++;
                    $display("FAIL limit_resp got s=%0d d=%h exp s=0 d=%h", host_status, host_read_data, v);
                end
            end
            step();
        end
        rv[0] = 1'b0;
        drive_hosts();
        i_ready = 1'b0;
        ptr_m = 1;
    endtask

    task automatic test_random();
        int          w;
        int          d;
        logic [1:0]  st;
        logic [31:0] rdv;
        logic        exp_done;
        for (int n = 0; n < 150; n++) begin
            for (int h = 0; h < 2; h++) begin
                if (!rv[h] && $urandom_range(1, 0) == 1) begin
                    rv[h] = 1'b1; rw[h] = 1'($urandom_range(1, 0)); ra[h] = 16'($urandom);
                    rd[h] = $urandom; rs[h] = 4'($urandom);
                end
            end
            drive_hosts();
            i_ready = 1'($urandom_range(1, 0)); i_status = 2'($urandom); i_read_data = $urandom;
            #1;
            checks++;
            if (o_valid !== 1'b0 || host_ready !== 2'b00) begin
                errors++;
                $display("FAIL rnd_idle txn%0d got v=%b rdy=%b exp v=0 rdy=00", n, o_valid, host_ready);
            end
            if (!rv[0] && !rv[1]) begin
                step();
                continue;
            end
            w = rv[ptr_m] ? ptr_m : 1 - ptr_m;
            step();
            d = $urandom_range(5, 0);
            for (int b = 0; b < 4; b++) begin
                st = 2'($urandom); rdv = $urandom;
                i_ready = (b == d); i_status = st; i_read_data = rdv;
                #1;
                exp_done = (b == d) || (b == 3);
                checks++;
                if ({o_valid, o_write, o_address, o_write_data, o_strobe} !== {1'b1, rw[w], ra[w], rd[w], rs[w]}) begin
                    errors++;
                    $display("FAIL rnd_payload txn%0d got %h exp %h", n,
                             {o_valid, o_write, o_address, o_write_data, o_strobe}, {1'b1, rw[w], ra[w], rd[w], rs[w]});
                end
                checks++;
                if (host_ready !== (exp_done ? 2'(1 << w) : 2'b00)) begin
                    errors++;
                    $display("FAIL rnd_ready txn%0d cyc%0d got %b exp %b", n, b, host_ready, exp_done ? 2'(1 << w) : 2'b00);
                end
                if (exp_done) begin
                    checks++;
                    if (host_status !== ((b == d) ? st : 2'd2) || host_read_data !== ((b == d && !rw[w]) ? rdv : 32'h0)) begin
                        errors++;
                        $display("FAIL rnd_resp txn%0d got s=%0d d=%h exp s=%0d d=%h", n, host_status, host_read_data,
                                 (b == d) ? st : 2'd2, (b == d && !rw[w]) ? rdv : 32'h0);
                    end
                    rv[w] = 1'b0;
                    ptr_m = (w + 1) % 2;
                end
                step();
                if (exp_done) break;
            end
        end
        rv[0] = 1'b0; rv[1] = 1'b0;
        drive_hosts();
        i_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 16'h0100;
        drive_hosts();
        i_ready = 1'b0;
        step();
        i_ready = 1'b1; i_status = 2'd0;
        #1;
        checks++;
        if (host_ready !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_pre got %b exp 01", host_ready);
        end
        step();
        rv[1] = 1'b1; rw[1] = 1'b1; ra[1] = 16'h0200;
        drive_hosts();
        i_ready = 1'b0;
        step();
        #1;
        checks++;
        if (o_valid !== 1'b1 || o_address !== 16'h0200) begin
            errors++;
            $display("FAIL rstmid_grant1 got v=%b a=%h exp v=1 a=0200", o_valid, o_address);
        end
        i_ready = 1'b1;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || host_ready !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_async got v=%b rdy=%b exp v=0 rdy=00", o_valid, host_ready);
        end
        step();
        step();
        i_rst_n = 1'b1;
        ptr_m = 0;
        #1;
        checks++;
        if (host_ready !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_idle got %b exp 00", host_ready);
        end
        step();
        checks++;
        if (host_ready !== 2'b01 || o_address !== 16'h0100) begin
            errors++;
            $display("FAIL rstmid_regrant got rdy=%b a=%h exp rdy=01 a=0100", host_ready, o_address);
        end
        step();
        rv[0] = 1'b0; rv[1] = 1'b0;
        drive_hosts();
        i_ready = 1'b0;
        ptr_m = 1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ptr_m = 0;
        i_rst_n = 1'b1;
        i_ready = 1'b0;
        i_status = 2'd0;
        i_read_data = 32'h0;
        for (int h = 0; h < 2; h++) begin
            rv[h] = 1'b0; rw[h] = 1'b0; ra[h] = '0; rd[h] = '0; rs[h] = '0;
        end
        drive_hosts();
        #1;
        test_reset();
        test_single_read();
        test_write_hold();
        test_back_to_back();
        test_timeout();
        test_ready_at_limit();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1);
    end
endmodule
